// File: rtl/rst_seq_pkg.sv
// Shared types and default timing constants for the staged reset release controller.
package rst_seq_pkg;

  localparam int unsigned CNT_W       = 20;
  localparam int unsigned STAGE_IDX_W = 3;

  localparam logic [1:0] S_HOLD_ALL = 2'd0;
  localparam logic [1:0] S_GAP      = 2'd1;
  localparam logic [1:0] S_WAIT_ACK = 2'd2;
  localparam logic [1:0] S_RUN      = 2'd3;

  typedef enum logic [1:0] {
    HOLD_ALL = S_HOLD_ALL,
    GAP      = S_GAP,
    WAIT_ACK = S_WAIT_ACK,
    RUN      = S_RUN
  } state_e;

  // Hardware and shrunk simulation values for each cycle count
  localparam int unsigned STAGE_GAP_HW    = 3000;
  localparam int unsigned STAGE_GAP_SIM   = 4;
  localparam int unsigned TIMEOUT_HW      = 300000;
  localparam int unsigned TIMEOUT_SIM     = 32;
  localparam int unsigned DEBOUNCE_HW     = 30000;
  localparam int unsigned DEBOUNCE_SIM    = 8;
  localparam int unsigned HOLD_CYC_HW     = 3000;
  localparam int unsigned HOLD_CYC_SIM    = 16;

endpackage

// File: rtl/rst_seq_ctrl_if.sv
// Soft-reset request, per-stage acknowledge and sequencer status bundle.
interface rst_seq_ctrl_if #(
  parameter int unsigned NUM_STAGE = 4
);
  import rst_seq_pkg::*;

  logic                   soft_rst_req;
  logic [NUM_STAGE-1:0]   stage_done;
  logic [NUM_STAGE-1:0]   rst_stage_o;
  logic                   seq_busy;
  logic                   seq_done;
  logic                   timeout_err;
  logic [STAGE_IDX_W-1:0] timeout_stage;

  modport master (
    output soft_rst_req, stage_done,
    input  rst_stage_o, seq_busy, seq_done, timeout_err, timeout_stage
  );

  modport slave (
    input  soft_rst_req, stage_done,
    output rst_stage_o, seq_busy, seq_done, timeout_err, timeout_stage
  );

endinterface

// File: rtl/rst_req_debounce.sv
// Synchronizes an asynchronous soft-reset level and emits one pulse per
// sufficiently long high period.
module rst_req_debounce
  import rst_seq_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYC = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic req_i,
  output logic hit_o
);

  logic             r_sync1;
  logic             r_sync2;
  logic [CNT_W-1:0] r_cnt;
  logic             r_hit;

  // Saturating count means the pulse fires once until the level drops again
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
      r_cnt   <= '0;
      r_hit   <= 1'b0;
    end else begin
      r_sync1 <= req_i;
      r_sync2 <= r_sync1;
      if (!r_sync2) begin
        r_cnt <= '0;
      end else if (r_cnt != CNT_W'(DEBOUNCE_CYC)) begin
        r_cnt <= r_cnt + CNT_W'(1);
      end
      r_hit <= r_sync2 && (r_cnt == CNT_W'(DEBOUNCE_CYC - 1));
    end
  end

  assign hit_o = r_hit;

endmodule

// File: rtl/rst_seq_ctrl.sv
// Releases NUM_STAGE downstream reset domains in order, each gated by the
// previous stage's acknowledge or a timeout; soft requests restart the sequence.
module rst_seq_ctrl
  import rst_seq_pkg::*;
#(
  parameter string       SIMULATION   = "FALSE",
  parameter int unsigned NUM_STAGE    = 4,
  parameter int unsigned STAGE_GAP    = (SIMULATION == "FALSE") ? STAGE_GAP_HW : STAGE_GAP_SIM,
  parameter int unsigned TIMEOUT      = (SIMULATION == "FALSE") ? TIMEOUT_HW   : TIMEOUT_SIM,
  parameter int unsigned DEBOUNCE_CYC = (SIMULATION == "FALSE") ? DEBOUNCE_HW  : DEBOUNCE_SIM,
  parameter int unsigned HOLD_CYC     = (SIMULATION == "FALSE") ? HOLD_CYC_HW  : HOLD_CYC_SIM
) (
  input  logic           clk,
  input  logic           rst,
  rst_seq_ctrl_if.slave  io_seq
);

  state_e                 r_state, w_state_nxt;
  logic [CNT_W-1:0]       r_cnt, w_cnt_nxt;
  logic [STAGE_IDX_W-1:0] r_k, w_k_nxt;
  logic                   r_hold_sat, w_hold_sat_nxt;
  logic [NUM_STAGE-1:0]   r_rst_stage, w_rst_stage_nxt;
  logic                   r_seq_done, w_seq_done_nxt;
  logic                   r_seq_busy;
  logic                   r_terr, w_terr_nxt;
  logic [STAGE_IDX_W-1:0] r_tstage, w_tstage_nxt;
  logic                   w_soft_hit;
  logic                   w_ack;

  rst_req_debounce #(
    .DEBOUNCE_CYC (DEBOUNCE_CYC)
  ) u_debounce (
    .clk   (clk),
    .rst   (rst),
    .req_i (io_seq.soft_rst_req),
    .hit_o (w_soft_hit)
  );

  // State and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= HOLD_ALL;
      r_cnt       <= '0;
      r_k         <= '0;
      r_hold_sat  <= 1'b1;
      r_rst_stage <= '1;
      r_seq_done  <= 1'b0;
      r_seq_busy  <= 1'b1;
      r_terr      <= 1'b0;
      r_tstage    <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_cnt       <= w_cnt_nxt;
      r_k         <= w_k_nxt;
      r_hold_sat  <= w_hold_sat_nxt;
      r_rst_stage <= w_rst_stage_nxt;
      r_seq_done  <= w_seq_done_nxt;
      r_seq_busy  <= ~w_seq_done_nxt;
      r_terr      <= w_terr_nxt;
      r_tstage    <= w_tstage_nxt;
    end
  end

  // Next-state and output computation
  always_comb begin
    w_state_nxt     = r_state;
    w_cnt_nxt       = r_cnt;
    w_k_nxt         = r_k;
    w_hold_sat_nxt  = r_hold_sat;
    w_rst_stage_nxt = r_rst_stage;
    w_terr_nxt      = r_terr;
    w_tstage_nxt    = r_tstage;
    w_ack           = 1'b0;

    // Only the acknowledge of the stage currently being waited on matters
    for (int i = 0; i < int'(NUM_STAGE); i++) begin
      if (STAGE_IDX_W'(i) == r_k) begin
        w_ack = io_seq.stage_done[i];
      end
    end

    if (w_soft_hit) begin
      w_state_nxt     = HOLD_ALL;
      w_cnt_nxt       = '0;
      w_k_nxt         = '0;
      w_hold_sat_nxt  = 1'b0;
      w_rst_stage_nxt = '1;
    end else begin
      case (r_state)
        HOLD_ALL: begin
          // After power-on reset the hold is treated as already served
          if (r_hold_sat || (r_cnt == CNT_W'(HOLD_CYC - 1))) begin
            w_state_nxt = GAP;
            w_cnt_nxt   = '0;
            w_k_nxt     = '0;
          end else begin
            w_cnt_nxt = r_cnt + CNT_W'(1);
          end
        end
        GAP: begin
          if (r_cnt == CNT_W'(STAGE_GAP)) begin
            for (int i = 0; i < int'(NUM_STAGE); i++) begin
              if (STAGE_IDX_W'(i) == r_k) begin
                w_rst_stage_nxt[i] = 1'b0;
              end
            end
            w_state_nxt = WAIT_ACK;
            w_cnt_nxt   = '0;
          end else begin
            w_cnt_nxt = r_cnt + CNT_W'(1);
          end
        end
        WAIT_ACK: begin
          if (w_ack || (r_cnt == CNT_W'(TIMEOUT - 1))) begin
            if (!w_ack) begin
              w_terr_nxt   = 1'b1;
              w_tstage_nxt = r_k;
            end
            w_cnt_nxt = '0;
            if (r_k == STAGE_IDX_W'(NUM_STAGE - 1)) begin
              w_state_nxt = RUN;
            end else begin
              w_k_nxt     = r_k + STAGE_IDX_W'(1);
              w_state_nxt = GAP;
            end
          end else begin
            w_cnt_nxt = r_cnt + CNT_W'(1);
          end
        end
        RUN: begin
          w_state_nxt = RUN;
        end
        default: begin
          w_state_nxt = HOLD_ALL;
          w_cnt_nxt   = '0;
        end
      endcase
    end

    w_seq_done_nxt = (w_state_nxt == RUN);
  end

  assign io_seq.rst_stage_o   = r_rst_stage;
  assign io_seq.seq_busy      = r_seq_busy;
  assign io_seq.seq_done      = r_seq_done;
  assign io_seq.timeout_err   = r_terr;
  assign io_seq.timeout_stage = r_tstage;

endmodule

// File: tb/tb_rst_seq_ctrl.sv
// Directed bench for rst_seq_ctrl in simulation timing (gap 4, timeout 32,
// debounce 8, hold 16) with four stages.
module tb_rst_seq_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_checks = 0;
  int   n_errors = 0;
  int   n_edge   = 0;
  int   at;

  always #5 clk = ~clk;

  rst_seq_ctrl_if #(.NUM_STAGE(4)) u_if ();

  rst_seq_ctrl #(
    .SIMULATION ("TRUE"),
    .NUM_STAGE  (4)
  ) u_dut (
    .clk    (clk),
    .rst    (rst),
    .io_seq (u_if.slave)
  );

  task automatic step(input int cnt = 1);
    repeat (cnt) begin
      @(posedge clk);
      #1;
      n_edge++;
    end
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Returns the edge number on which stage idx was released, -1 if never
  task automatic wait_fall(input int idx, input int budget, output int edge_no);
    edge_no = -1;
    for (int i = 0; i < budget; i++) begin
      step();
      if (u_if.rst_stage_o[idx] === 1'b0) begin
        edge_no = n_edge;
        break;
      end
    end
  endtask

  task automatic wait_done(input int budget, output int edge_no);
    edge_no = -1;
    for (int i = 0; i < budget; i++) begin
      step();
      if (u_if.seq_done === 1'b1) begin
        edge_no = n_edge;
        break;
      end
    end
  endtask

  task automatic wait_all_held(input int budget, output int edge_no);
    edge_no = -1;
    for (int i = 0; i < budget; i++) begin
      step();
      if (u_if.rst_stage_o === 4'hF) begin
        edge_no = n_edge;
        break;
      end
    end
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_rst_stage"}, 32'(u_if.rst_stage_o), 32'hF);
    check({tag, "_busy"},      32'(u_if.seq_busy), 1);
    check({tag, "_done"},      32'(u_if.seq_done), 0);
    check({tag, "_terr"},      32'(u_if.timeout_err), 0);
    check({tag, "_tstage"},    32'(u_if.timeout_stage), 0);
  endtask

  initial begin
    u_if.soft_rst_req = 1'b0;
    u_if.stage_done   = 4'hF;

    // Power-on release with every stage acking immediately
    rst = 1'b1;
    step(3);
    check_reset_vals("por");
    rst = 1'b0;
    n_edge = 0;
    wait_fall(0, 20, at); check("t1_s0_fall", 32'(at), 6);
    wait_fall(1, 20, at); check("t1_s1_fall", 32'(at), 12);
    wait_fall(2, 20, at); check("t1_s2_fall", 32'(at), 18);
    wait_fall(3, 20, at); check("t1_s3_fall", 32'(at), 24);
    wait_done(10, at);    check("t1_done", 32'(at), 25);
    check("t1_busy", 32'(u_if.seq_busy), 0);
    check("t1_terr", 32'(u_if.timeout_err), 0);

    // Stage 2 never acks: timeout after 32 wait cycles, sequence continues
    rst = 1'b1;
    step(2);
    u_if.stage_done = 4'b1011;
    rst = 1'b0;
    n_edge = 0;
    wait_fall(2, 40, at); check("t2_s2_fall", 32'(at), 18);
    step(49 - n_edge);
    check("t2_terr_pre", 32'(u_if.timeout_err), 0);
    step();
    check("t2_terr", 32'(u_if.timeout_err), 1);
    check("t2_tstage", 32'(u_if.timeout_stage), 2);
    check("t2_s2_held_low", 32'(u_if.rst_stage_o[2]), 0);
    wait_fall(3, 20, at); check("t2_s3_fall", 32'(at), 55);
    wait_done(10, at);    check("t2_done", 32'(at), 56);
    u_if.stage_done = 4'b0000;
    step(5);
    check("t2_run_ignores_done", 32'(u_if.seq_done), 1);
    check("t2_run_stages", 32'(u_if.rst_stage_o), 0);

    // Short request is filtered; long request restarts everything
    u_if.stage_done   = 4'hF;
    u_if.soft_rst_req = 1'b1;
    step(7);
    u_if.soft_rst_req = 1'b0;
    step(12);
    check("t3_short_stages", 32'(u_if.rst_stage_o), 0);
    check("t3_short_done", 32'(u_if.seq_done), 1);
    n_edge = 0;
    u_if.soft_rst_req = 1'b1;
    wait_all_held(20, at); check("t3_hit_edge", 32'(at), 11);
    check("t3_hit_done", 32'(u_if.seq_done), 0);
    check("t3_hit_busy", 32'(u_if.seq_busy), 1);
    check("t3_terr_kept", 32'(u_if.timeout_err), 1);
    step(20 - n_edge);
    u_if.soft_rst_req = 1'b0;
    wait_fall(0, 40, at); check("t3_s0_fall", 32'(at), 32);
    wait_done(40, at);    check("t3_done", 32'(at), 51);
    check("t3_tstage_kept", 32'(u_if.timeout_stage), 2);

    // Soft hit while stage 1 waits for its ack
    u_if.stage_done   = 4'b1101;
    n_edge = 0;
    u_if.soft_rst_req = 1'b1;
    step(12);
    u_if.soft_rst_req = 1'b0;
    wait_fall(1, 60, at); check("t4_s1_fall", 32'(at), 38);
    n_edge = 0;
    u_if.soft_rst_req = 1'b1;
    step(10);
    check("t4_pre_hit", 32'(u_if.rst_stage_o), 4'b1100);
    step();
    check("t4_hit_all", 32'(u_if.rst_stage_o), 4'hF);
    check("t4_hit_done", 32'(u_if.seq_done), 0);
    step();
    u_if.soft_rst_req = 1'b0;
    u_if.stage_done   = 4'hF;
    wait_fall(0, 40, at); check("t4_s0_fall", 32'(at), 32);
    check("t4_terr_kept", 32'(u_if.timeout_err), 1);

    // Synchronous reset mid-sequence clears everything, including the error
    rst = 1'b1;
    step();
    check_reset_vals("mid");

    // Out-of-turn ack for stage 1 while stage 0 is still in its gap
    u_if.stage_done = 4'b0000;
    step(2);
    rst = 1'b0;
    n_edge = 0;
    step(2);
    u_if.stage_done = 4'b0010;
    step(2);
    u_if.stage_done = 4'b0000;
    wait_fall(0, 20, at); check("t6_s0_fall", 32'(at), 6);
    step(8 - n_edge);
    check("t6_s1_still_held", 32'(u_if.rst_stage_o[1]), 1);
    u_if.stage_done = 4'b0001;
    wait_fall(1, 20, at); check("t6_s1_fall", 32'(at), 14);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
